// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiply and
// restoring divide over WIDTH iterations, plus MTHI/MTLO moves while idle.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             moveHi,
    input  logic             moveLo,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [1:0]         op_reg;
    logic               neg_a_reg, neg_b_reg, dz_reg;
    logic [WIDTH-1:0]   opnd_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               busy_reg, done_reg, dz_out_reg;

    // Operand sign/magnitude; op[0]=1 selects the unsigned variants.
    logic             sign1, sign2;
    logic [WIDTH-1:0] mag1, mag2;
    assign sign1 = ~op[0] & data1[WIDTH-1];
    assign sign2 = ~op[0] & data2[WIDTH-1];
    assign mag1  = sign1 ? -data1 : data1;
    assign mag2  = sign2 ? -data2 : data2;

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, opnd_reg};
    assign mul_next = acc_reg[0] ? {mul_sum, acc_reg[WIDTH-1:1]}
                                 : {1'b0, acc_reg[2*WIDTH-1:1]};

    // Divide step: acc = {remainder, dividend bits shifting into quotient}.
    logic [WIDTH:0]     div_shift, div_trial;
    logic [2*WIDTH-1:0] div_next;
    assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd_reg};
    assign div_next  = div_trial[WIDTH]
                     ? {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                     : {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};

    // Sign fix-up; a zero-divisor remainder equals |dividend|, so restoring
    // its sign yields the original dividend bit pattern.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign prod_fix = (neg_a_reg ^ neg_b_reg) ? -acc_reg : acc_reg;
    assign quo_fix  = (neg_a_reg ^ neg_b_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    assign rem_fix  = neg_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt_reg == LAST_ITER) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg    <= '0;
            op_reg     <= '0;
            neg_a_reg  <= 1'b0;
            neg_b_reg  <= 1'b0;
            dz_reg     <= 1'b0;
            opnd_reg   <= '0;
            acc_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            dz_out_reg <= 1'b0;
        end else begin
            done_reg   <= 1'b0;
            dz_out_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (moveHi) hi_reg <= data1;
                    if (moveLo) lo_reg <= data1;
                    if (start) begin
                        op_reg    <= op;
                        neg_a_reg <= sign1;
                        neg_b_reg <= sign2;
                        dz_reg    <= op[1] & (data2 == '0);
                        opnd_reg  <= op[1] ? mag2 : mag1;
                        acc_reg   <= op[1] ? {{WIDTH{1'b0}}, mag1} : {{WIDTH{1'b0}}, mag2};
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                CALC: begin
                    acc_reg <= op_reg[1] ? div_next : mul_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                FINISH: begin
                    if (op_reg[1]) begin
                        hi_reg <= rem_fix;
                        lo_reg <= dz_reg ? {WIDTH{1'b1}} : quo_fix;
                    end else begin
                        hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fix[WIDTH-1:0];
                    end
                    done_reg   <= 1'b1;
                    dz_out_reg <= dz_reg;
                    busy_reg   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign divZero = dz_out_reg;
    assign hi      = hi_reg;
    assign lo      = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO/divZero and completion cycle
// are queued at issue and checked when done pulses.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] data1 = '0, data2 = '0;
    logic        moveHi = 1'b0, moveLo = 1'b0;
    logic        busy, done, divZero;
    logic [31:0] hi, lo;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   cycle = 0;
    int   compared = 0, mismatched = 0;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .data1(data1), .data2(data2), .moveHi(moveHi), .moveLo(moveLo),
        .busy(busy), .done(done), .divZero(divZero), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset === 1'b1) begin
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("cycle %0d: done hi=0x%08h lo=0x%08h divZero=%0b", cycle, hi, lo, divZero);
                    chk("hi", hi, e.hi);
                    chk("lo", lo, e.lo);
                    chk("divZero", 32'(divZero), 32'(e.dz));
                    chk("latency", 32'(cycle), 32'(e.due));
                end
            end else if (divZero === 1'b1) begin
                chk("divZero_without_done", 32'd1, 32'd0);
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz);
        exp_t e;
        @(negedge clock);
        start = 1'b1; op = o; data1 = a; data2 = b;
        e.hi = eh; e.lo = el; e.dz = edz; e.due = cycle + 34;
        exp_q.push_back(e);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hi_before;
        repeat (3) @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_divZero", 32'(divZero), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b1;

        // MULT 7 * -3 with cycle-by-cycle busy/done profile.
        issue(MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        for (int k = 0; k < 35; k++) begin
            chk($sformatf("busy_k%0d", k), 32'(busy), 32'(k < 33));
            chk($sformatf("done_k%0d", k), 32'(done), 32'(k == 33));
            @(negedge clock);
        end
        wait_done("mult_neg");

        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        wait_done("multu_max");
        issue(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
        wait_done("mult_m1");
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done("div_neg");
        issue(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        wait_done("divu");
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        wait_done("div_ovf");

        issue(DIVU, 32'h1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        wait_done("divu_zero");
        @(negedge clock);
        chk("divZero_pulse_end", 32'(divZero), 32'd0);
        issue(DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        wait_done("div_zero_neg");

        // Restart and move while busy must be ignored.
        issue(MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
        hi_before = hi;
        repeat (9) @(negedge clock);
        start = 1'b1; op = DIVU; data1 = 32'hAA; data2 = 32'd1; moveHi = 1'b1;
        @(negedge clock);
        start = 1'b0; moveHi = 1'b0;
        chk("busy_move_hi", hi, hi_before);
        wait_done("restart_ignored");

        @(negedge clock);
        data1 = 32'hAA; moveHi = 1'b1;
        @(negedge clock);
        moveHi = 1'b0;
        chk("mthi_idle", hi, 32'hAA);
        data1 = 32'h55; moveHi = 1'b1; moveLo = 1'b1;
        @(negedge clock);
        moveHi = 1'b0; moveLo = 1'b0;
        chk("mthi_both", hi, 32'h55);
        chk("mtlo_both", lo, 32'h55);

        // Move coinciding with start: move lands first, result overwrites.
        begin
            exp_t e;
            start = 1'b1; op = MULTU; data1 = 32'd6; data2 = 32'd7; moveLo = 1'b1;
            e.hi = 32'd0; e.lo = 32'd42; e.dz = 1'b0; e.due = cycle + 34;
            exp_q.push_back(e);
            @(negedge clock);
            start = 1'b0; moveLo = 1'b0;
            chk("mtlo_with_start", lo, 32'd6);
        end
        wait_done("start_with_move");

        // Asynchronous reset mid-calculation.
        issue(MULT, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0);
        repeat (14) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_hi", hi, 32'd0);
        chk("async_rst_lo", lo, 32'd0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        issue(MULT, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0);
        wait_done("after_reset");

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
